stat_resp_misr: RTL

- Downstream response compactor for the 32-output generated Stat benchmarks.
- Accepts one 32-bit benchmark output vector per valid/ready beat and folds it into a 32-bit MISR signature.
- Counts beats up to a programmed vector count, then reports the final signature and a pass/fail compare against a golden value.
- Sits directly after the combinational benchmark in the BIST/characterisation harness.

---
 rtl/stat_resp_misr_if.sv | 12 +
 rtl/stat_resp_misr.sv | 116 +++++++++++
 2 files changed

// File: rtl/stat_resp_misr_if.sv
// Response stream carrying one benchmark output vector per valid/ready beat.
// The producer drives valid/data; the compactor returns ready.
interface stat_resp_misr_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stat_resp_misr.sv
// MISR response compactor for the 32-output Stat benchmarks: folds a fixed number of beats into a
// signature and compares it with a golden value. Optional X-masking via STAT_RESP_MISR_XMASK_EN.
module stat_resp_misr #(
  parameter int unsigned     WIDTH = 32,
  parameter int unsigned     CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY = 32'h04C11DB7,
  parameter logic [WIDTH-1:0] SEED = 32'hFFFFFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic [WIDTH-1:0]    golden,
`ifdef STAT_RESP_MISR_XMASK_EN
  input  logic [WIDTH-1:0]    xmask,
`endif
  stat_resp_misr_if.slave     resp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [WIDTH-1:0]    signature,
  output logic [CNT_W-1:0]    vec_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] num_q;
  logic [WIDTH-1:0] golden_q;
  logic [WIDTH-1:0] data_m;
  logic [WIDTH-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

`ifdef STAT_RESP_MISR_XMASK_EN
  logic [WIDTH-1:0] xmask_q;
  assign data_m = resp.data & ~xmask_q;
`else
  assign data_m = resp.data;
`endif

  // Ready is a pure function of state so the producer never sees a valid->ready loop.
  assign resp.ready = (state_q == StRun);
  assign beat       = resp.valid & resp.ready;
  assign cnt_inc    = vec_count + CNT_W'(1);
  assign sig_next   = {signature[WIDTH-2:0], 1'b0}
                    ^ (signature[WIDTH-1] ? POLY : '0)
                    ^ data_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      vec_count <= '0;
      num_q     <= '0;
      golden_q  <= '0;
`ifdef STAT_RESP_MISR_XMASK_EN
      xmask_q   <= '0;
`endif
    end else if (abort) begin
      // Signature and count are left untouched for post-mortem inspection.
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            signature <= SEED;
            vec_count <= '0;
            num_q     <= num_vec;
            golden_q  <= golden;
`ifdef STAT_RESP_MISR_XMASK_EN
            xmask_q   <= xmask;
`endif
            if (num_vec == '0) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (SEED == golden);
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end
        end
        StRun: begin
          if (beat) begin
            signature <= sig_next;
            vec_count <= cnt_inc;
            if (cnt_inc == num_q) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (sig_next == golden_q);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule
